// File: rtl/strand_select_stage.sv
// strand_select_stage: picks one ready strand per cycle from the fetch FIFOs and registers it toward decode.
// Optional idle-cycle counter on ss_idle_cycles is built only when STRAND_SELECT_PERF_EN is defined.

module arbiter #(
    parameter int NUM = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [NUM-1:0] request,
    input  logic           update_lru,
    output logic [NUM-1:0] grant
);
    localparam int IW = (NUM > 1) ? $clog2(NUM) : 1;

    logic [IW-1:0] prio;
    logic [IW-1:0] grant_idx;
    logic [IW-1:0] idx;
    logic          any;

    // Search starts at the strand after the last winner.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        idx       = '0;
        any       = 1'b0;
        for (int i = 0; i < NUM; i++) begin
            idx = IW'((int'(prio) + i) % NUM);
            if (!any && request[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                any        = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            prio <= '0;
        else if (update_lru && any)
            prio <= (grant_idx == IW'(NUM - 1)) ? '0 : grant_idx + 1'b1;
    end
endmodule

module strand_state #(
    parameter int LONG_EXTRA_CYCLES = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic rollback,
    input  logic suspend,
    input  logic resume,
    input  logic issue_long,
    output logic ready
);
    localparam int CW = ($clog2(LONG_EXTRA_CYCLES + 1) > 2) ? $clog2(LONG_EXTRA_CYCLES + 1) : 2;

    typedef enum logic [1:0] {READY, LONG_WAIT, SUSPENDED} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= READY;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Rollback overrides everything; a coincident resume cancels the suspend.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (rollback) begin
            state_nxt = (suspend && !resume) ? SUSPENDED : READY;
            cnt_nxt   = '0;
        end else begin
            case (state)
                READY: begin
                    if (issue_long) begin
                        state_nxt = LONG_WAIT;
                        cnt_nxt   = CW'(LONG_EXTRA_CYCLES);
                    end
                end
                LONG_WAIT: begin
                    if (cnt <= CW'(1)) begin
                        state_nxt = READY;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt - 1'b1;
                    end
                end
                SUSPENDED: begin
                    if (resume)
                        state_nxt = READY;
                end
                default: begin
                    state_nxt = READY;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign ready = (state == READY);
endmodule

module strand_select_stage #(
    parameter int STRANDS_PER_CORE   = 4,
    parameter int STRAND_INDEX_WIDTH = (STRANDS_PER_CORE > 1) ? $clog2(STRANDS_PER_CORE) : 1,
    parameter int LONG_EXTRA_CYCLES  = 3
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [STRANDS_PER_CORE-1:0]      if_instruction_valid,
    input  logic [STRANDS_PER_CORE*32-1:0]   if_instruction,
    input  logic [STRANDS_PER_CORE*32-1:0]   if_pc,
    input  logic [STRANDS_PER_CORE-1:0]      if_branch_predicted,
    input  logic [STRANDS_PER_CORE-1:0]      if_long_latency,
    output logic [STRANDS_PER_CORE-1:0]      ss_instruction_req,
    input  logic [STRANDS_PER_CORE-1:0]      strand_enable,
    input  logic [STRANDS_PER_CORE-1:0]      rb_rollback_strand,
    input  logic [STRANDS_PER_CORE-1:0]      rb_suspend_strand,
    input  logic [STRANDS_PER_CORE-1:0]      resume_strand,
    output logic                             ss_instruction_valid,
    output logic [31:0]                      ss_instruction,
    output logic [31:0]                      ss_pc,
    output logic [STRAND_INDEX_WIDTH-1:0]    ss_strand,
    output logic                             ss_branch_predicted,
    output logic                             ss_long_latency,
    output logic [31:0]                      ss_idle_cycles
);
    localparam int N = STRANDS_PER_CORE;
    localparam int L = LONG_EXTRA_CYCLES;

    logic [N-1:0]                  ready, eligible, grant;
    logic [L-1:0]                  long_pipe;
    logic                          issue_long, any_grant;
    logic [31:0]                   sel_instr, sel_pc;
    logic [STRAND_INDEX_WIDTH-1:0] sel_strand;
    logic                          sel_bp, sel_long;

    generate
        for (genvar n = 0; n < N; n++) begin : g_strand
            strand_state #(.LONG_EXTRA_CYCLES(L)) u_state (
                .clk        (clk),
                .reset      (reset),
                .rollback   (rb_rollback_strand[n]),
                .suspend    (rb_suspend_strand[n]),
                .resume     (resume_strand[n]),
                .issue_long (grant[n] & if_long_latency[n]),
                .ready      (ready[n])
            );
            // A short op would land on the writeback port in the same cycle as the oldest long op.
            assign eligible[n] = if_instruction_valid[n] & strand_enable[n] & ready[n]
                               & ~rb_rollback_strand[n]
                               & ~(long_pipe[L-1] & ~if_long_latency[n]);
        end
    endgenerate

    arbiter #(.NUM(N)) u_arb (
        .clk        (clk),
        .reset      (reset),
        .request    (eligible),
        .update_lru (1'b1),
        .grant      (grant)
    );

    assign ss_instruction_req = grant;
    assign any_grant          = |grant;
    assign issue_long         = |(grant & if_long_latency);

    always_comb begin
        sel_instr  = '0;
        sel_pc     = '0;
        sel_strand = '0;
        sel_bp     = 1'b0;
        sel_long   = 1'b0;
        for (int n = 0; n < N; n++) begin
            if (grant[n]) begin
                sel_instr  = if_instruction[n*32 +: 32];
                sel_pc     = if_pc[n*32 +: 32];
                sel_strand = STRAND_INDEX_WIDTH'(n);
                sel_bp     = if_branch_predicted[n];
                sel_long   = if_long_latency[n];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            long_pipe <= '0;
        end else begin
            long_pipe[0] <= issue_long;
            for (int i = 1; i < L; i++)
                long_pipe[i] <= long_pipe[i-1];
        end
    end

    // Without a grant every field drops to 0 so decode sees a clean NOP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ss_instruction_valid <= 1'b0;
            ss_instruction       <= '0;
            ss_pc                <= '0;
            ss_strand            <= '0;
            ss_branch_predicted  <= 1'b0;
            ss_long_latency      <= 1'b0;
        end else begin
            ss_instruction_valid <= any_grant;
            ss_instruction       <= sel_instr;
            ss_pc                <= sel_pc;
            ss_strand            <= sel_strand;
            ss_branch_predicted  <= sel_bp;
            ss_long_latency      <= sel_long;
        end
    end

`ifdef STRAND_SELECT_PERF_EN
    logic [31:0] idle_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            idle_cnt <= '0;
        else if (!any_grant)
            idle_cnt <= idle_cnt + 32'd1;
    end

    assign ss_idle_cycles = idle_cnt;
`else
    assign ss_idle_cycles = 32'd0;
`endif
endmodule

// File: doc/strand_select_stage.md
Name: strand_select_stage

Overview:
- Sits directly downstream of the instruction fetch stage and upstream of decode.
- Each cycle it picks at most one strand that has a valid instruction at the head of its fetch FIFO, dequeues it, and registers it into the decode pipeline.
- Tracks per-strand issue state: ready, long-latency wait, or suspended on a data-cache miss.
- Blocks writeback-port collisions between the short and long arithmetic pipelines.

Parameters:
- LONG_EXTRA_CYCLES, 3, extra pipeline depth of the long-latency arithmetic path versus the short path; sets both the strand stall length and the collision slot.

Ports:
clk  input  1  core clock
reset  input  1  asynchronous, active-high reset
if_instruction_valid  input  STRANDS_PER_CORE  per-strand FIFO head valid
if_instruction  input  STRANDS_PER_CORE*32  per-strand head instruction (strand n at bits n*32+:32)
if_pc  input  STRANDS_PER_CORE*32  per-strand PC of the instruction after the head
if_branch_predicted  input  STRANDS_PER_CORE  per-strand predicted-taken flag
if_long_latency  input  STRANDS_PER_CORE  per-strand long-pipeline flag
ss_instruction_req  output  STRANDS_PER_CORE  one-hot dequeue to fetch (combinational)
strand_enable  input  STRANDS_PER_CORE  strand running mask from control registers
rb_rollback_strand  input  STRANDS_PER_CORE  rollback per strand
rb_suspend_strand  input  STRANDS_PER_CORE  suspend; qualified by rb_rollback_strand
resume_strand  input  STRANDS_PER_CORE  data-cache load complete
ss_instruction_valid  output  1  registered issue valid
ss_instruction  output  32  registered instruction; 0 (NOP) when not valid
ss_pc  output  32  registered PC
ss_strand  output  STRAND_INDEX_WIDTH  registered strand index
ss_branch_predicted  output  1  registered flag
ss_long_latency  output  1  registered flag
ss_idle_cycles  output  32  perf counter (see Optional Feature)

Behaviour:
- Per-strand FSM: READY, LONG_WAIT, SUSPENDED. Reset: all strands READY. Each strand has a 2-bit-or-wider wait counter, reset 0.
- Eligible(n) = if_instruction_valid[n] & strand_enable[n] & state==READY & ~rb_rollback_strand[n] & ~collision(n).
- Collision: a LONG_EXTRA_CYCLES-deep shift register records long issues. collision(n) is true when the register's oldest bit is set (a long op issued LONG_EXTRA_CYCLES cycles earlier) and if_long_latency[n]==0.
- Selection: round-robin via `arbiter` (update_lru=1) over eligible strands. Grant drives ss_instruction_req in the same cycle, so at most one bit is set and the FIFO dequeues that cycle.
- Issue registers: loaded on the next clock edge with the granted strand's fields; ss_instruction_valid=1. With no grant: valid=0, instruction=0, other fields hold 0.
- Reset value of all outputs: 0.
- Issuing a long-latency instruction: strand goes READY to LONG_WAIT, counter=LONG_EXTRA_CYCLES. Counter decrements each cycle; strand returns to READY when the counter reaches 1→0, so the strand is ineligible for exactly LONG_EXTRA_CYCLES cycles.
- rb_rollback_strand[n] & rb_suspend_strand[n]: strand goes to SUSPENDED from any state.
- rb_rollback_strand[n] alone: strand goes to READY and the counter clears.
- rb_suspend_strand without rollback: ignored.
- SUSPENDED to READY on resume_strand[n].
- Resume and suspend-rollback in the same cycle on the same strand: resume wins, strand goes READY.
- Rollback does not squash the already-registered output; the rollback controller squashes downstream.
- Deasserting strand_enable only blocks eligibility. State machine and counter continue to run.
- Reset mid-operation: all state, the shift register and the output registers clear asynchronously.

Optional Feature:
- Macro: STRAND_SELECT_PERF_EN.
- Defined: ss_idle_cycles is a 32-bit counter, reset 0, incremented on every cycle with no grant. It wraps from 0xFFFFFFFF to 0.
- Undefined: ss_idle_cycles is tied to 0 and no counter flops exist.

Test Plan:
- 4 strands all valid and READY, short instructions: grants 0,1,2,3,0 on consecutive cycles; ss_strand follows one cycle later with valid=1.
- Strand 1 issues a long op at cycle t, only strand 1 valid: no grant at t+1..t+3, grant at t+4.
- Strand 0 issues a long op at t; strand 2 has a short op and strand 3 a long op: at t+3 only strand 3 may be granted; strand 2 is granted at t+4.
- Rollback+suspend on strand 2, then resume at +5 cycles: strand 2 gets no grants while suspended and is eligible the cycle after resume. Resume in the same cycle as suspend leaves the strand READY.
- No valid strands for 10 cycles with STRAND_SELECT_PERF_EN: ss_idle_cycles=10, ss_instruction=0, valid=0. Without the macro it reads 0.
- Reset asserted mid-stream with strand 1 in LONG_WAIT: outputs 0 immediately, strand 1 eligible on the first cycle after reset release.
